// File: rtl/coleco_pad_responder_pkg.sv
// Shared definitions for the ColecoVision pad responder: button bit positions,
// keypad pin codes, poll FSM states and the small decode helpers.
package coleco_pad_pkg;

    localparam int BTN_B     = 0;
    localparam int BTN_Y     = 1;
    localparam int BTN_SEL   = 2;
    localparam int BTN_START = 3;
    localparam int BTN_UP    = 4;
    localparam int BTN_DOWN  = 5;
    localparam int BTN_LEFT  = 6;
    localparam int BTN_RIGHT = 7;
    localparam int BTN_A     = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_L     = 10;
    localparam int BTN_R     = 11;

    // Active-low {P3,P2,P1,P0} nibbles the console's keypad scan expects.
    localparam logic [3:0] KP_NONE = 4'hF;
    localparam logic [3:0] KP_1    = 4'hD;
    localparam logic [3:0] KP_2    = 4'h7;
    localparam logic [3:0] KP_3    = 4'hC;
    localparam logic [3:0] KP_4    = 4'h2;
    localparam logic [3:0] KP_STAR = 4'h9;
    localparam logic [3:0] KP_HASH = 4'h6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SHIFT,
        ST_COMMIT
    } pad_state_e;

    function automatic logic [3:0] keypad_code(input logic [11:0] btn);
        logic [3:0] code;
        code = KP_NONE;
        if (btn[BTN_X])          code = KP_1;
        else if (btn[BTN_Y])     code = KP_2;
        else if (btn[BTN_L])     code = KP_3;
        else if (btn[BTN_R])     code = KP_4;
        else if (btn[BTN_SEL])   code = KP_STAR;
        else if (btn[BTN_START]) code = KP_HASH;
        return code;
    endfunction

    // Opposing directions held together cancel out, as on a real stick.
    function automatic logic [11:0] mask_dirs(input logic [11:0] btn);
        logic [11:0] m;
        m = btn;
        if (btn[BTN_UP] && btn[BTN_DOWN]) begin
            m[BTN_UP]   = 1'b0;
            m[BTN_DOWN] = 1'b0;
        end
        if (btn[BTN_LEFT] && btn[BTN_RIGHT]) begin
            m[BTN_LEFT]  = 1'b0;
            m[BTN_RIGHT] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/coleco_pad_responder_if.sv
// Pin bundle between the console glue, the serial gamepad and the responder.
interface coleco_pad_responder_if;
    logic        arm_n;
    logic        fire_n;
    logic        pad_data;
    logic        pad_latch;
    logic        pad_clk;
    logic [5:0]  ctrl_p;
    logic        pad_valid;
    logic [11:0] buttons;

    modport master (
        output arm_n, fire_n, pad_data,
        input  pad_latch, pad_clk, ctrl_p, pad_valid, buttons
    );

    modport slave (
        input  arm_n, fire_n, pad_data,
        output pad_latch, pad_clk, ctrl_p, pad_valid, buttons
    );
endinterface

// File: rtl/coleco_pad_serial.sv
// Polls the SNES-style pad: latch pulse, 16 shift clocks, then commits the
// decoded button state once per frame.
module coleco_pad_serial
    import coleco_pad_pkg::*;
#(
    parameter int HALF_DIV = 21,
    parameter int POLL_DIV = 59659
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pad_data_i,
    output logic        pad_latch_o,
    output logic        pad_clk_o,
    output logic [11:0] buttons_o,
    output logic        pad_valid_o
);
    localparam int PW = $clog2(POLL_DIV);
    localparam int TW = $clog2(2 * HALF_DIV);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
    localparam logic [TW-1:0] TMR_LAST  = TW'(2 * HALF_DIV - 1);
    localparam logic [TW-1:0] TMR_HALF  = TW'(HALF_DIV);

    pad_state_e    state_q, state_d;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [15:0]   shreg_q, shreg_d;
    logic          pad_latch_q, pad_latch_d;
    logic          pad_clk_q, pad_clk_d;
    logic [11:0]   buttons_q, buttons_d;
    logic          pad_valid_q, pad_valid_d;
    logic [1:0]    data_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            poll_cnt_q  <= '0;
            tmr_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '1;
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b1;
            buttons_q   <= '0;
            pad_valid_q <= 1'b0;
            data_sync_q <= 2'b11;
        end else begin
            state_q     <= state_d;
            poll_cnt_q  <= poll_cnt_d;
            tmr_q       <= tmr_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            pad_latch_q <= pad_latch_d;
            pad_clk_q   <= pad_clk_d;
            buttons_q   <= buttons_d;
            pad_valid_q <= pad_valid_d;
            data_sync_q <= {data_sync_q[0], pad_data_i};
        end
    end

    always_comb begin
        state_d     = state_q;
        poll_cnt_d  = (poll_cnt_q == POLL_LAST) ? '0 : poll_cnt_q + 1'b1;
        tmr_d       = tmr_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        pad_latch_d = pad_latch_q;
        pad_clk_d   = pad_clk_q;
        buttons_d   = buttons_q;
        pad_valid_d = pad_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (poll_cnt_q == POLL_LAST) begin
                    state_d     = ST_LATCH;
                    pad_latch_d = 1'b1;
                    tmr_d       = '0;
                end
            end
            ST_LATCH: begin
                if (tmr_q == TMR_LAST) begin
                    state_d     = ST_SHIFT;
                    pad_latch_d = 1'b0;
                    tmr_d       = '0;
                    bit_idx_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                tmr_d = tmr_q + 1'b1;
                // Sample at the start of each bit, half a period after the rising edge.
                if (tmr_q == '0) begin
                    shreg_d[bit_idx_q] = data_sync_q[1];
                    pad_clk_d          = 1'b0;
                end
                if (tmr_q == TMR_HALF) pad_clk_d = 1'b1;
                if (tmr_q == TMR_LAST) begin
                    tmr_d = '0;
                    if (bit_idx_q == 4'd15) state_d = ST_COMMIT;
                    else                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                // A genuine pad always shifts out ones after its twelve buttons.
                if (&shreg_q[15:12]) begin
                    buttons_d   = mask_dirs(~shreg_q[11:0]);
                    pad_valid_d = 1'b1;
                end else begin
                    buttons_d   = '0;
                    pad_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pad_latch_o = pad_latch_q;
    assign pad_clk_o   = pad_clk_q;
    assign buttons_o   = buttons_q;
    assign pad_valid_o = pad_valid_q;

endmodule

// File: rtl/coleco_pad_responder.sv
// Controller-side responder: synchronizes the two commons from the glue and
// drives the six active-low pins from the last committed pad frame.
module coleco_pad_responder
    import coleco_pad_pkg::*;
#(
    parameter int HALF_DIV = 21,
    parameter int POLL_DIV = 59659
) (
    input  logic                   clk,
    input  logic                   rst,
    coleco_pad_responder_if.slave  bus
);
    logic [11:0] btn;
    logic [1:0]  meta_q;
    logic [1:0]  sync_q;
    logic [5:0]  ctrl_q, ctrl_d;
    logic        sa, sf;

    coleco_pad_serial #(
        .HALF_DIV (HALF_DIV),
        .POLL_DIV (POLL_DIV)
    ) u_serial (
        .clk         (clk),
        .rst         (rst),
        .pad_data_i  (bus.pad_data),
        .pad_latch_o (bus.pad_latch),
        .pad_clk_o   (bus.pad_clk),
        .buttons_o   (btn),
        .pad_valid_o (bus.pad_valid)
    );

    // Bit 0 carries arm_n, bit 1 fire_n; both idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
            ctrl_q <= 6'h3F;
        end else begin
            meta_q <= {bus.fire_n, bus.arm_n};
            sync_q <= meta_q;
            ctrl_q <= ctrl_d;
        end
    end

    assign sa = sync_q[0];
    assign sf = sync_q[1];

    always_comb begin
        ctrl_d = 6'h3F;
        if (!sf) begin
            ctrl_d = {~btn[BTN_B], 1'b1, ~btn[BTN_LEFT], ~btn[BTN_DOWN],
                      ~btn[BTN_RIGHT], ~btn[BTN_UP]};
        end else if (!sa) begin
            ctrl_d = {~btn[BTN_A], 1'b1, keypad_code(btn)};
        end
    end

    assign bus.ctrl_p  = ctrl_q;
    assign bus.buttons = btn;

endmodule

// File: tb/tb_coleco_pad_responder.sv
// Directed bench for coleco_pad_responder with a behavioural serial pad model.
module tb_coleco_pad_responder;
    localparam int HALF_DIV = 21;
    localparam int POLL_DIV = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    coleco_pad_responder_if bus();

    coleco_pad_responder #(
        .HALF_DIV (HALF_DIV),
        .POLL_DIV (POLL_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Pad model: bit 0 presented while latched, each pad_clk rise advances.
    logic [15:0] pad_frame  = 16'hFFFF;
    logic        pad_absent = 1'b0;
    int          pad_bit    = 0;
    always @(posedge bus.pad_latch) pad_bit = 0;
    always @(posedge bus.pad_clk) if (!bus.pad_latch) pad_bit = pad_bit + 1;
    assign bus.pad_data = pad_absent ? 1'b0 :
                          (pad_bit < 16) ? pad_frame[pad_bit[3:0]] : 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_latch(output int n);
        n = 0;
        while (bus.pad_latch !== 1'b1 && n < 2 * POLL_DIV) begin
            @(negedge clk);
            n++;
        end
        if (bus.pad_latch !== 1'b1) chk("latch_timeout", 16'd0, 16'd1);
    endtask

    // Load a frame, check pins hold mid-shift, then wait until it has committed.
    task automatic run_frame(input string tag, input logic [15:0] frame,
                             input logic absent, input logic [5:0] hold);
        int n;
        pad_frame  = frame;
        pad_absent = absent;
        wait_latch(n);
        cycles(400);
        chk({tag, "_hold"}, 16'(bus.ctrl_p), 16'(hold));
        cycles(400);
    endtask

    initial begin
        int n, w, lows, falls;
        logic prev;
        bus.arm_n  = 1'b1;
        bus.fire_n = 1'b1;
        cycles(3);
        chk("rst_latch",  16'(bus.pad_latch), 16'd0);
        chk("rst_padclk", 16'(bus.pad_clk),   16'd1);
        chk("rst_ctrl",   16'(bus.ctrl_p),    16'h3F);
        chk("rst_valid",  16'(bus.pad_valid), 16'd0);
        chk("rst_btn",    16'(bus.buttons),   16'h0);
        rst = 1'b0;

        // First frame timing with an idle pad
        wait_latch(n);
        chk("latch_start", 16'(n), 16'(POLL_DIV));
        w = 0;
        while (bus.pad_latch === 1'b1 && w < 200) begin
            cycles(1);
            w++;
        end
        chk("latch_width", 16'(w), 16'(2 * HALF_DIV));
        lows = 0; falls = 0; prev = 1'b1;
        for (int i = 0; i < 800; i++) begin
            cycles(1);
            if (!bus.pad_clk) begin
                lows++;
                if (prev) falls++;
            end
            prev = bus.pad_clk;
        end
        chk("clk_pulses", 16'(falls), 16'd16);
        chk("clk_low_total", 16'(lows), 16'(16 * HALF_DIV));
        chk("idle_valid", 16'(bus.pad_valid), 16'd1);
        chk("idle_btn",   16'(bus.buttons),   16'h0);
        chk("idle_ctrl",  16'(bus.ctrl_p),    16'h3F);

        // Up + B, joystick mode, with common latency
        run_frame("upb", 16'hFFEE, 1'b0, 6'h3F);
        chk("upb_btn", 16'(bus.buttons), 16'h011);
        chk("upb_ctrl_nocommon", 16'(bus.ctrl_p), 16'h3F);
        bus.fire_n = 1'b0;
        cycles(2);
        chk("fire_lat2", 16'(bus.ctrl_p), 16'h3F);
        cycles(1);
        chk("fire_lat3", 16'(bus.ctrl_p), 16'h1E);

        // Keypad mode
        bus.arm_n = 1'b0; bus.fire_n = 1'b1;
        run_frame("kp_start_l", 16'hFBF7, 1'b0, 6'h3F);
        chk("kp_start_l_btn",  16'(bus.buttons), 16'h408);
        chk("kp_start_l_ctrl", 16'(bus.ctrl_p),  16'h3C);
        run_frame("kp_a", 16'hFAF7, 1'b0, 6'h3C);
        chk("kp_a_ctrl", 16'(bus.ctrl_p), 16'h1C);
        run_frame("kp_xysel", 16'hFDF9, 1'b0, 6'h1C);
        chk("kp_xysel_btn",  16'(bus.buttons), 16'h206);
        chk("kp_xysel_ctrl", 16'(bus.ctrl_p),  16'h3D);

        // Both commons low: joystick wins
        bus.arm_n = 1'b0; bus.fire_n = 1'b0;
        run_frame("both_right", 16'hFF7F, 1'b0, 6'h3F);
        chk("both_right_btn",  16'(bus.buttons), 16'h080);
        chk("both_right_ctrl", 16'(bus.ctrl_p),  16'h3D);
        run_frame("updown", 16'hFFCF, 1'b0, 6'h3D);
        chk("updown_btn",  16'(bus.buttons), 16'h000);
        chk("updown_ctrl", 16'(bus.ctrl_p),  16'h3F);
        run_frame("lr_b", 16'hFF3E, 1'b0, 6'h3F);
        chk("lr_b_btn",  16'(bus.buttons), 16'h001);
        chk("lr_b_ctrl", 16'(bus.ctrl_p),  16'h1F);

        // Absent pad
        bus.arm_n = 1'b1; bus.fire_n = 1'b0;
        run_frame("absent", 16'hFFFF, 1'b1, 6'h1F);
        chk("absent_valid", 16'(bus.pad_valid), 16'd0);
        chk("absent_btn",   16'(bus.buttons),   16'h000);
        chk("absent_joy",   16'(bus.ctrl_p),    16'h3F);
        bus.arm_n = 1'b0; bus.fire_n = 1'b1;
        cycles(4);
        chk("absent_kp", 16'(bus.ctrl_p), 16'h3F);

        // Reset in the middle of bit 7
        bus.arm_n = 1'b1; bus.fire_n = 1'b0;
        run_frame("pre_rst", 16'hFFEE, 1'b0, 6'h3F);
        chk("pre_rst_ctrl", 16'(bus.ctrl_p), 16'h1E);
        wait_latch(n);
        falls = 0; prev = bus.pad_clk; w = 0;
        while (falls < 8 && w < 2000) begin
            cycles(1);
            w++;
            if (prev && !bus.pad_clk) falls++;
            prev = bus.pad_clk;
        end
        chk("bit7_reached", 16'(falls), 16'd8);
        cycles(5);
        rst = 1'b1;
        #1;
        chk("midrst_padclk", 16'(bus.pad_clk),   16'd1);
        chk("midrst_latch",  16'(bus.pad_latch), 16'd0);
        chk("midrst_ctrl",   16'(bus.ctrl_p),    16'h3F);
        chk("midrst_valid",  16'(bus.pad_valid), 16'd0);
        cycles(2);
        rst = 1'b0;
        wait_latch(n);
        chk("post_rst_latch", 16'(n), 16'(POLL_DIV));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coleco_pad_responder.md
Name: coleco_pad_responder

Overview:
- Controller-side end of the ColecoVision joystick/keypad interface. The glue block drives the two common strobes (arm_n = keypad/arm common, fire_n = joystick/fire common) and samples six active-low pins.
- This block polls an SNES-style serial gamepad, latches its button state, and drives the six pins from that state according to which common is asserted.
- It replaces the passive diode-matrix controller.
- One instance per player; outputs feed the glue's CxP0..CxP3, CxP5, CxP6 inputs.

Parameters:
- HALF_DIV, 21: clk cycles per half period of pad_clk (≈6 us at 3.58 MHz); legal range ≥2.
- POLL_DIV, 59659: clk cycles between poll starts (≈60 Hz); must exceed 36*HALF_DIV.

Ports:
- clk  in  1  system clock (glue clock domain).
- rst  in  1  asynchronous, active-high reset.
- arm_n  in  1  keypad/arm common from glue, active low, asynchronous to pad.
- fire_n  in  1  joystick/fire common from glue, active low.
- pad_data  in  1  serial data from gamepad, low = pressed, pulled up externally.
- pad_latch  out  1  gamepad latch pulse, active high.
- pad_clk  out  1  gamepad shift clock, idles high.
- ctrl_p  out  6  {P6,P5,P3,P2,P1,P0} to glue, active low.
- pad_valid  out  1  last frame accepted.
- buttons  out  12  pressed state, active high: [0]B [1]Y [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right [8]A [9]X [10]L [11]R.

Behaviour:
- Reset (async, any state): state=IDLE, timers=0, pad_latch=0, pad_clk=1, buttons=0, pad_valid=0, ctrl_p=6'h3F.
- Poll FSM: IDLE → LATCH → SHIFT → COMMIT → IDLE.
  - IDLE: poll_cnt counts 0..POLL_DIV-1. At terminal count go to LATCH. The counter free-runs across the frame, so poll start spacing is exactly POLL_DIV.
  - LATCH: pad_latch=1 for 2*HALF_DIV cycles, then pad_latch=0, bit_idx=0 → SHIFT.
  - SHIFT, per bit: on entry sample pad_data into shreg[bit_idx], drive pad_clk=0 for HALF_DIV cycles, then pad_clk=1 for HALF_DIV cycles; the rising edge advances the pad. After bit_idx 15 completes → COMMIT.
  - COMMIT (1 cycle): frame valid iff raw bits 15:12 == 4'b1111.
    - Valid: buttons <= ~shreg[11:0], pad_valid<=1.
    - Invalid (pad absent or pulled low): buttons <= 0, pad_valid<=0.
- Direction masking at COMMIT:
  - Up&Down both pressed → both reported released.
  - Left&Right likewise.
  - Masking applies to the buttons output.
- Commons: arm_n and fire_n each pass through a 2-flop synchronizer (sa, sf).
- Pin mux, registered, total latency 3 clk from common edge to ctrl_p:
  - sf=0 (joystick mode, priority over sa): P0=~Up, P1=~Right, P2=~Down, P3=~Left, P6=~B, P5=1.
  - sa=0, sf=1 (keypad mode): {P3..P0}=keypad code, P6=~A, P5=1.
  - Both high: 6'h3F.
- Keypad codes (raw, active-low nibble {P3,P2,P1,P0}):
  - none=F, '1'=D, '2'=7, '3'=C, '4'=2, '*'=9, '#'=6.
  - Map: X='1', Y='2', L='3', R='4', Select='*', Start='#'.
  - Priority when several are pressed: X>Y>L>R>Select>Start.
- ctrl_p reflects the committed buttons only; a frame in progress never affects the pins.
- A common change mid-frame affects the pins within 3 clk regardless of FSM state.

Decomposition:
- Package coleco_pad_pkg:
  - Button index localparams (BTN_B..BTN_R).
  - Keypad code constants (KP_NONE, KP_1..KP_4, KP_STAR, KP_HASH).
  - FSM state enum.
- Sub-module coleco_pad_serial: LATCH/SHIFT/COMMIT FSM with its counters. Outputs buttons and pad_valid.
- Top level holds the synchronizers and the pin mux.

Test Plan:
- Reset release, pad model returning 16'hFFFF → first pad_latch high at poll_cnt terminal (cycle POLL_DIV), width 42 clk; exactly 16 pad_clk low pulses of 21 clk; pad_valid=1, buttons=0, ctrl_p=6'h3F.
- Pad frame with Up and B pressed (raw 16'hFFEE), fire_n=0 → 3 clk after commit/common, ctrl_p=6'b011110 (P6=0, P0=0).
- Keypad mode, arm_n=0, fire_n=1, Start and L pressed → {P3..P0}=4'hC ('3' wins), P6=1.
  - Repeat with A pressed → P6=0.
- Both commons low with Right pressed → joystick mapping wins: P1=0.
  - Up+Down pressed → P0=P2=1.
- pad_data tied low (absent pad) → pad_valid=0, buttons=0, ctrl_p=6'h3F in both modes.
- Assert rst mid-SHIFT (bit 7) → same cycle pad_clk=1, pad_latch=0, ctrl_p=6'h3F; after release the next latch starts POLL_DIV cycles later.
